// File: rtl/rfphoenix_dc_hitplru.sv
// N-way data-cache hit detector with per-set tree pseudo-LRU victim selection.
// Registers hit/way/multi-hit and the refill victim one cycle after each lookup.
module rfphoenix_dc_hitplru #(
    parameter  int AWID  = 32,
    parameter  int WAYS  = 4,
    parameter  int SETS  = 128,
    parameter  int LOBIT = 6,
    localparam int WB    = $clog2(WAYS),
    localparam int NB    = $clog2(SETS),
    localparam int TAGW  = AWID - LOBIT
) (
    input  logic                 rst,
    input  logic                 clk,
    input  logic                 req,
    input  logic [NB-1:0]        ndx,
    input  logic [AWID-1:0]      adr,
    input  logic [WAYS*TAGW-1:0] tags,
    input  logic [WAYS*SETS-1:0] valid,
    input  logic                 fill,
    input  logic [NB-1:0]        fill_ndx,
    input  logic [WB-1:0]        fill_way,
    output logic [WAYS-1:0]      hits,
    output logic                 rdy,
    output logic                 hit,
    output logic [WB-1:0]        rway,
    output logic                 multi,
    output logic [WB-1:0]        victim
);

    // Heap-ordered tree: node n lives in bit n-1, leaves map to ways WAYS..2*WAYS-1.
    function automatic logic [WB-1:0] plru_walk(input logic [WAYS-2:0] st);
        logic [WB:0] node;
        logic        b;
        node = (WB+1)'(1);
        for (int l = 0; l < WB; l++) begin
            b = 1'b0;
            for (int n = 1; n < WAYS; n++)
                if (node == (WB+1)'(n)) b = st[n-1];
            node = {node[WB-1:0], b};
        end
        return node[WB-1:0];
    endfunction

    // Each node on the way's path is flipped to point at the opposite subtree.
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] st,
                                                   input logic [WB-1:0]   w);
        logic [WAYS-2:0] r;
        logic [WB:0]     path;
        r    = st;
        path = {1'b1, w};
        for (int l = 0; l < WB; l++)
            for (int n = 1; n < WAYS; n++)
                if ((path >> (WB - l)) == (WB+1)'(n)) r[n-1] = ~w[WB-1-l];
        return r;
    endfunction

    logic [WAYS-1:0][TAGW-1:0] tag_way;
    logic [WAYS-1:0][SETS-1:0] vld_way;
    logic [TAGW-1:0]           adr_tag;
    logic [WAYS-2:0]           plru [SETS];

    logic                      hit_any;
    logic [WB-1:0]             hit_way;
    logic [WB:0]               hit_cnt;
    logic                      multi_c;
    logic                      free_any;
    logic [WB-1:0]             free_way;
    logic [WB-1:0]             vic_c;
    logic                      hit_touch;

    assign tag_way = tags;
    assign vld_way = valid;
    assign adr_tag = adr[AWID-1:LOBIT];

    always_comb begin
        hits = '0;
        for (int w = 0; w < WAYS; w++)
            hits[w] = (tag_way[w] == adr_tag) && vld_way[w][ndx];
    end

    // Priority encoders scan downward so the lowest index wins.
    always_comb begin
        hit_any  = |hits;
        hit_way  = '0;
        hit_cnt  = '0;
        free_any = 1'b0;
        free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hits[w]) hit_way = WB'(w);
            if (!vld_way[w][ndx]) begin
                free_any = 1'b1;
                free_way = WB'(w);
            end
            hit_cnt = hit_cnt + (WB+1)'(hits[w]);
        end
        multi_c = hit_cnt > (WB+1)'(1);
        vic_c   = free_any ? free_way : plru_walk(plru[ndx]);
    end

    // A fill to the looked-up set supersedes the hit touch for that cycle.
    assign hit_touch = req && hit_any && !(fill && (fill_ndx == ndx));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) plru[s] <= '0;
        end else begin
            if (hit_touch) plru[ndx] <= plru_touch(plru[ndx], hit_way);
            if (fill)      plru[fill_ndx] <= plru_touch(plru[fill_ndx], fill_way);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy    <= 1'b0;
            hit    <= 1'b0;
            multi  <= 1'b0;
            rway   <= '0;
            victim <= '0;
        end else begin
            rdy   <= req;
            hit   <= req && hit_any;
            multi <= req && multi_c;
            if (req) begin
                victim <= vic_c;
                if (hit_any) rway <= hit_way;
            end
        end
    end

endmodule

// File: tb/tb_rfphoenix_dc_hitplru.sv
// Bench for rfphoenix_dc_hitplru: directed vector table, reset corner,
// 8-way PLRU sequences and random traffic against a range-bisection PLRU model.
module tb_rfphoenix_dc_hitplru;
    localparam int AWID = 32, WAYS = 4, SETS = 128, LOBIT = 6, TAGW = AWID - LOBIT;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic                 req = 0, fill = 0;
    logic [6:0]           ndx = 0, fill_ndx = 0;
    logic [AWID-1:0]      adr = 0;
    logic [WAYS*TAGW-1:0] tags = 0;
    logic [WAYS*SETS-1:0] valid = 0;
    logic [1:0]           fill_way = 0;
    logic [3:0]           hits;
    logic                 rdy, hit, multi;
    logic [1:0]           rway, victim;

    rfphoenix_dc_hitplru #(.AWID(AWID), .WAYS(WAYS), .SETS(SETS), .LOBIT(LOBIT)) dut (
        .rst(rst), .clk(clk), .req(req), .ndx(ndx), .adr(adr), .tags(tags), .valid(valid),
        .fill(fill), .fill_ndx(fill_ndx), .fill_way(fill_way), .hits(hits), .rdy(rdy),
        .hit(hit), .rway(rway), .multi(multi), .victim(victim));

    logic          req8 = 0, fill8 = 0;
    logic [6:0]    ndx8 = 0, fill_ndx8 = 0;
    logic [31:0]   adr8 = 0;
    logic [8*26-1:0] tags8 = 0;
    logic [8*128-1:0] valid8 = 0;
    logic [2:0]    fill_way8 = 0;
    logic [7:0]    hits8;
    logic          rdy8, hit8, multi8;
    logic [2:0]    rway8, victim8;

    rfphoenix_dc_hitplru #(.AWID(32), .WAYS(8), .SETS(128), .LOBIT(6)) u8 (
        .rst(rst), .clk(clk), .req(req8), .ndx(ndx8), .adr(adr8), .tags(tags8), .valid(valid8),
        .fill(fill8), .fill_ndx(fill_ndx8), .fill_way(fill_way8), .hits(hits8), .rdy(rdy8),
        .hit(hit8), .rway(rway8), .multi(multi8), .victim(victim8));

    int total = 0, bad = 0;
    bit mp [SETS][WAYS];   // mp[s][n]: node n of set s, 1 = upper half is next victim side
    int e_rway = 0, e_victim = 0;
    bit e_rdy = 0, e_hit = 0, e_multi = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int s = 0; s < SETS; s++) for (int n = 0; n < WAYS; n++) mp[s][n] = 0;
        e_rway = 0; e_victim = 0;
    endtask

    function automatic int m_walk(input int s);
        int lo = 0, hi = WAYS, n = 1, mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mp[s][n]) begin lo = mid; n = 2 * n + 1; end
            else          begin hi = mid; n = 2 * n;     end
        end
        return lo;
    endfunction

    task automatic m_touch(input int s, input int w);
        int lo = 0, hi = WAYS, n = 1, mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            mp[s][n] = (w < mid);
            if (w >= mid) begin lo = mid; n = 2 * n + 1; end
            else          begin hi = mid; n = 2 * n;     end
        end
    endtask

    task automatic setup(input int s, input logic [3:0] vmask, input logic [3:0] match);
        ndx = 7'(s);
        adr = $urandom;
        for (int w = 0; w < WAYS; w++) begin
            valid[w*SETS + s] = vmask[w];
            tags[w*TAGW +: TAGW] = match[w] ? adr[AWID-1:LOBIT] : adr[AWID-1:LOBIT] ^ TAGW'(w + 1);
        end
    endtask

    // One lookup cycle: inputs already driven while clk is low.
    task automatic step();
        logic [3:0] mh;
        int lw;
        #1;
        for (int w = 0; w < WAYS; w++)
            mh[w] = (tags[w*TAGW +: TAGW] == adr[AWID-1:LOBIT]) && valid[w*SETS + int'(ndx)];
        chk("hits", 32'(hits), 32'(mh));
        lw = -1;
        for (int w = 0; w < WAYS; w++) if (mh[w] && lw < 0) lw = w;
        if (req) begin
            e_rdy = 1; e_hit = (lw >= 0); e_multi = ($countones(mh) > 1);
            if (lw >= 0) e_rway = lw;
            e_victim = -1;
            for (int w = 0; w < WAYS; w++)
                if (!valid[w*SETS + int'(ndx)] && e_victim < 0) e_victim = w;
            if (e_victim < 0) e_victim = m_walk(int'(ndx));
        end else begin
            e_rdy = 0; e_hit = 0; e_multi = 0;
        end
        if (req && lw >= 0 && !(fill && fill_ndx == ndx)) m_touch(int'(ndx), lw);
        if (fill) m_touch(int'(fill_ndx), int'(fill_way));
        @(posedge clk);
        @(negedge clk);
        chk("rdy", 32'(rdy), 32'(e_rdy));
        chk("hit", 32'(hit), 32'(e_hit));
        chk("multi", 32'(multi), 32'(e_multi));
        chk("rway", 32'(rway), 32'(e_rway));
        chk("victim", 32'(victim), 32'(e_victim));
    endtask

    task automatic plru8(input int s, input logic [27:0] ord, input int expv);
        for (int i = 0; i < 7; i++) begin
            fill8 = 1; fill_ndx8 = 7'(s); fill_way8 = ord[4*i +: 3];
            @(negedge clk);
        end
        fill8 = 0; req8 = 1; ndx8 = 7'(s); valid8 = '1; tags8 = '0; adr8 = 32'hFFFF_FFC0;
        @(negedge clk);
        chk($sformatf("w8.set%0d.victim", s), 32'(victim8), 32'(expv));
        chk("w8.hit", 32'(hit8), 32'd0);
        req8 = 0;
    endtask

    typedef struct {
        bit req; int ndx; logic [3:0] vmask; logic [3:0] match;
        bit fill; int fndx; int fway;
        bit e_hit; int e_rway; bit e_multi; int e_victim;
    } vec_t;
    vec_t tbl[$];

    initial begin
        m_reset();
        //            req ndx vmask    match    fill fn fw  hit rway multi victim
        tbl.push_back('{1, 5, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 9, 4'b1111, 4'b0100, 0, 0, 0, 1, 2, 0, 0});
        tbl.push_back('{1, 9, 4'b1111, 4'b0000, 0, 0, 0, 0, 2, 0, 0});
        tbl.push_back('{0, 9, 4'b1111, 4'b0000, 0, 0, 0, 0, 2, 0, 0});
        tbl.push_back('{1, 3, 4'b1111, 4'b0001, 0, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{1, 3, 4'b1111, 4'b0100, 0, 0, 0, 1, 2, 0, 2});
        tbl.push_back('{1, 3, 4'b1111, 4'b0010, 0, 0, 0, 1, 1, 0, 1});
        tbl.push_back('{1, 3, 4'b1111, 4'b0000, 0, 0, 0, 0, 1, 0, 3});
        tbl.push_back('{1, 11, 4'b1111, 4'b1010, 0, 0, 0, 1, 1, 1, 0});
        tbl.push_back('{1, 7, 4'b1111, 4'b0001, 0, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{1, 7, 4'b1111, 4'b0100, 0, 0, 0, 1, 2, 0, 2});
        tbl.push_back('{1, 7, 4'b1111, 4'b0010, 0, 0, 0, 1, 1, 0, 1});
        tbl.push_back('{1, 7, 4'b1111, 4'b0000, 0, 0, 0, 0, 1, 0, 3});
        tbl.push_back('{1, 7, 4'b1101, 4'b0000, 0, 0, 0, 0, 1, 0, 1});
        tbl.push_back('{1, 4, 4'b1111, 4'b0001, 1, 4, 3, 1, 0, 0, 0});
        tbl.push_back('{1, 4, 4'b1111, 4'b0000, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 4, 4'b1111, 4'b0001, 1, 6, 3, 1, 0, 0, 0});
        tbl.push_back('{1, 4, 4'b1111, 4'b0000, 0, 0, 0, 0, 0, 0, 2});
        tbl.push_back('{1, 6, 4'b1111, 4'b0000, 0, 0, 0, 0, 0, 0, 0});

        repeat (2) @(negedge clk);
        chk("rst.rdy", 32'(rdy), 0);
        chk("rst.hit", 32'(hit), 0);
        chk("rst.rway", 32'(rway), 0);
        chk("rst.multi", 32'(multi), 0);
        chk("rst.victim", 32'(victim), 0);
        rst = 0;
        @(negedge clk);

        foreach (tbl[i]) begin
            req = tbl[i].req;
            fill = tbl[i].fill; fill_ndx = 7'(tbl[i].fndx); fill_way = 2'(tbl[i].fway);
            setup(tbl[i].ndx, tbl[i].vmask, tbl[i].match);
            step();
            chk($sformatf("v%0d.rdy", i), 32'(rdy), 32'(tbl[i].req));
            chk($sformatf("v%0d.hit", i), 32'(hit), 32'(tbl[i].e_hit));
            chk($sformatf("v%0d.rway", i), 32'(rway), 32'(tbl[i].e_rway));
            chk($sformatf("v%0d.multi", i), 32'(multi), 32'(tbl[i].e_multi));
            chk($sformatf("v%0d.victim", i), 32'(victim), 32'(tbl[i].e_victim));
        end
        fill = 0;

        // Reset lands while a hit is registered and the next lookup is still driven.
        req = 1;
        setup(3, 4'b1111, 4'b0001);
        step();
        chk("pre_rst.victim", 32'(victim), 3);
        rst = 1;
        #1;
        chk("mid_rst.rdy", 32'(rdy), 0);
        chk("mid_rst.hit", 32'(hit), 0);
        chk("mid_rst.victim", 32'(victim), 0);
        chk("mid_rst.rway", 32'(rway), 0);
        m_reset();
        req = 0;
        @(negedge clk);
        rst = 0;
        step();
        chk("post_rst.rdy", 32'(rdy), 0);
        req = 1;
        setup(3, 4'b1111, 4'b0000);
        step();
        chk("post_rst.victim", 32'(victim), 0);

        // Random traffic over a few sets so hits and fills collide often.
        for (int c = 0; c < 400; c++) begin
            req = ($urandom_range(0, 3) != 0);
            fill = ($urandom_range(0, 3) == 0);
            fill_ndx = 7'($urandom_range(0, 7));
            fill_way = 2'($urandom_range(0, 3));
            setup($urandom_range(0, 7), 4'($urandom | $urandom),
                  ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'b0000);
            step();
        end
        req = 0; fill = 0;

        plru8(2, 28'h6543210, 0);
        plru8(3, 28'h3516240, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
